mole_spawner: RTL

Upstream stage of the difficulty timer. Picks a pseudo-random hole, lights its LED, fires a one-cycle `start` pulse to the timer, then resolves the round as hit, miss (timer timeout) or wrong press. The idle gap between rounds is set by difficulty level. Sits between the button debouncers / timer and the score block.

---
 rtl/whack_pkg.sv | 22 ++
 rtl/mole_spawner_if.sv | 28 ++
 rtl/lfsr16.sv | 17 +
 rtl/mole_spawner.sv | 123 ++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game blocks.
package whack_pkg;

    typedef enum logic [1:0] {IDLE, GAP, SPAWN, WAIT} state_t;

    typedef enum logic [1:0] {
        LVL_EASY  = 2'd0,
        LVL_MED   = 2'd1,
        LVL_HARD  = 2'd2,
        LVL_HARD2 = 2'd3
    } level_t;

    localparam int LFSR_W    = 16;
    localparam int GAP_CNT_W = 5;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    // Galois step: shift right, fold the taps in when the outgoing bit is set.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Game-side bundle of the mole spawner: controls and presses in, LED drive and round results out.
interface mole_spawner_if #(
    parameter int N_HOLES = 8
);
    localparam int IDX_W = $clog2(N_HOLES);

    logic               enable;
    logic [1:0]         level;
    logic [N_HOLES-1:0] btn_pulse;
    logic               timeout_pulse;
    logic               start;
    logic [N_HOLES-1:0] mole_onehot;
    logic [IDX_W-1:0]   mole_idx;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               wrong_pulse;

    modport master (
        output enable, level, btn_pulse, timeout_pulse,
        input  start, mole_onehot, mole_idx, hit_pulse, miss_pulse, wrong_pulse
    );

    modport slave (
        input  enable, level, btn_pulse, timeout_pulse,
        output start, mole_onehot, mole_idx, hit_pulse, miss_pulse, wrong_pulse
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, shared by the game's random sources.
module lfsr16
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEED;
        else     state <= lfsr_next(state);
    end

endmodule

// File: rtl/mole_spawner.sv
// Round sequencer: gap, spawn a random mole, resolve hit/miss/wrong press.
// Optional MOLE_NO_REPEAT_EN: never light the same hole on two consecutive spawns.
module mole_spawner
    import whack_pkg::*;
#(
    parameter int                N_HOLES        = 8,
    parameter int                GAP_TICKS_EASY = 6,
    parameter int                GAP_TICKS_MED  = 4,
    parameter int                GAP_TICKS_HARD = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
    input  logic          clk_game,
    input  logic          rst,
    mole_spawner_if.slave bus
);

    localparam int IDX_W = $clog2(N_HOLES);

    state_t               state;
    logic [GAP_CNT_W-1:0] cnt;
    logic [GAP_CNT_W-1:0] gap_lim;
    logic [LFSR_W-1:0]    lfsr;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     idx_q;
    logic [N_HOLES-1:0]   onehot_q;
    logic                 start_q, hit_q, miss_q, wrong_q;
    logic                 unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk_game),
        .rst   (rst),
        .state (lfsr)
    );

    assign cand        = lfsr[IDX_W-1:0];
    assign unused_lfsr = ^lfsr[LFSR_W-1:IDX_W];

`ifdef MOLE_NO_REPEAT_EN
    // idx_q still holds the previous spawn here; power-of-two width makes +1 wrap mod N_HOLES.
    assign pick = (cand == idx_q) ? cand + IDX_W'(1) : cand;
`else
    assign pick = cand;
`endif

    always_comb begin
        gap_lim = GAP_CNT_W'(GAP_TICKS_HARD);
        case (level_t'(bus.level))
            LVL_EASY: gap_lim = GAP_CNT_W'(GAP_TICKS_EASY);
            LVL_MED:  gap_lim = GAP_CNT_W'(GAP_TICKS_MED);
            default:  gap_lim = GAP_CNT_W'(GAP_TICKS_HARD);
        endcase
    end

    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            start_q  <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            wrong_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            wrong_q <= 1'b0;
            if (!bus.enable) begin
                state    <= IDLE;
                cnt      <= '0;
                onehot_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= GAP;
                        cnt   <= '0;
                    end
                    GAP: begin
                        wrong_q <= |bus.btn_pulse;
                        // >= so a level change mid-gap can only shorten it, never stall it
                        if (cnt >= gap_lim - GAP_CNT_W'(1)) state <= SPAWN;
                        else                                cnt   <= cnt + GAP_CNT_W'(1);
                    end
                    SPAWN: begin
                        idx_q    <= pick;
                        onehot_q <= N_HOLES'(1) << pick;
                        start_q  <= 1'b1;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (bus.btn_pulse[idx_q]) begin
                            hit_q    <= 1'b1;
                            onehot_q <= '0;
                            cnt      <= '0;
                            state    <= GAP;
                        end else if (bus.timeout_pulse) begin
                            miss_q   <= 1'b1;
                            onehot_q <= '0;
                            cnt      <= '0;
                            state    <= GAP;
                        end else if (|bus.btn_pulse) begin
                            wrong_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.start       = start_q;
    assign bus.mole_onehot = onehot_q;
    assign bus.mole_idx    = idx_q;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;
    assign bus.wrong_pulse = wrong_q;

endmodule
